// File: rtl/core_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for the pipeline control blocks of the 5-stage core.
//   ctrl_state_e : stall controller FSM state (RUN / MEM_WAIT)
//   REG_X0       : architectural zero register index (never a hazard source)
// ---------------------------------------------------------------------------
package core_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears count
//   inc   : count this cycle
//   count : current value (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_r;

  // Saturating increment register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Stall/flush sequencing for the 5-stage core: load-use bubbles, taken
// branch squashes and multi-cycle data-memory waits with a timeout.
//   clk, rst              : clock / asynchronous active-low reset
//   ResultSrcE0, RD_E     : load in E and its destination register
//   Rs1_D, Rs2_D          : source registers of the instruction in D
//   PCSrcE                : branch/jump taken in E
//   MemReqM, MemReadyM    : data-memory request / completion in M
//   StallF/D/E/M          : pipeline register holds
//   FlushD/E/W            : pipeline register clears
//   MemErr                : sticky memory-timeout flag
//   StallCnt, FlushCnt    : saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ResultSrcE0,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  import core_ctrl_pkg::*;

  localparam int              WC_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LIMIT = WC_W'(MEM_TIMEOUT);

  ctrl_state_e     state_r, state_next_s;
  logic [WC_W-1:0] wait_cnt_r, wait_cnt_next_s;
  logic            mem_err_r, err_set_s;
  logic            mem_stall_s, timeout_s, lw_stall_s;
  logic            flush_any_s;

  // Hazard terms; wait_cnt counts stall cycles already spent in this wait.
  always_comb begin
    mem_stall_s = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      RUN: begin
        mem_stall_s = MemReqM & ~MemReadyM;
      end
      MEM_WAIT: begin
        mem_stall_s = ~MemReadyM & (wait_cnt_r != WAIT_LIMIT);
        timeout_s   = ~MemReadyM & (wait_cnt_r == WAIT_LIMIT);
      end
      default: begin
        mem_stall_s = 1'b0;
        timeout_s   = 1'b0;
      end
    endcase
    lw_stall_s = ResultSrcE0 & (RD_E != REG_X0) &
                 ((RD_E == Rs1_D) | (RD_E == Rs2_D));
  end

  // State, wait counter and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= RUN;
      wait_cnt_r <= {WC_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      mem_err_r  <= mem_err_r | err_set_s;
    end
  end

  // Next-state logic; a timeout releases the pipeline and raises the error.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    err_set_s       = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_stall_s) begin
          state_next_s    = MEM_WAIT;
          wait_cnt_next_s = WC_W'(1);
        end else begin
          state_next_s    = RUN;
          wait_cnt_next_s = {WC_W{1'b0}};
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_next_s    = RUN;
          wait_cnt_next_s = {WC_W{1'b0}};
        end else if (timeout_s) begin
          state_next_s    = RUN;
          wait_cnt_next_s = {WC_W{1'b0}};
          err_set_s       = 1'b1;
        end else begin
          state_next_s    = MEM_WAIT;
          wait_cnt_next_s = wait_cnt_r + WC_W'(1);
        end
      end
      default: begin
        state_next_s    = RUN;
        wait_cnt_next_s = {WC_W{1'b0}};
      end
    endcase
  end

  // Pipeline controls; memory freeze overrides load-use and branch, and a
  // held PCSrcE simply takes effect once the freeze lifts.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst) begin
      StallF = 1'b0;
    end else if (mem_stall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall_s;
      StallD = lw_stall_s;
      FlushD = PCSrcE;
      FlushE = lw_stall_s | PCSrcE;
    end
  end

  assign MemErr      = mem_err_r;
  assign flush_any_s = FlushD | FlushE;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_any_s),
    .count (FlushCnt)
  );

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Stall/flush controller for the 5-stage pipelined RISC-V core; sits beside hazard_unit, which owns forwarding.
- Sequences pipeline-register enables and clears for load-use hazards, taken branches/jumps and multi-cycle data-memory waits.
- Enforces a memory-wait timeout with a sticky error flag.
- Keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive memory-wait stall cycles before forced release (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
ResultSrcE0  in  1  instruction in E is a load
RD_E  in  5  destination register of instruction in E
Rs1_D  in  5  source register 1 of instruction in D
Rs2_D  in  5  source register 2 of instruction in D
PCSrcE  in  1  branch/jump taken, resolved in E
MemReqM  in  1  instruction in M accesses data memory
MemReadyM  in  1  data memory completes access this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
StallM  out  1  hold EX/MEM register
FlushD  out  1  clear IF/ID register to bubble
FlushE  out  1  clear ID/EX register to bubble
FlushW  out  1  clear MEM/WB register to bubble
MemErr  out  1  sticky memory-timeout flag
StallCnt  out  CNT_W  cycles with StallF=1
FlushCnt  out  CNT_W  cycles with FlushD=1 or FlushE=1

Behaviour:
- Reset (rst=0, async):
  - state=RUN, wait_cnt=0, MemErr=0, StallCnt=0, FlushCnt=0.
  - All Stall*/Flush* outputs forced 0 while rst=0.
- FSM states:
  - RUN: no memory wait outstanding.
  - MEM_WAIT: memory access pending.
- Internal terms (combinational):
  - mem_stall:
    - RUN: MemReqM & ~MemReadyM.
    - MEM_WAIT: ~MemReadyM & (wait_cnt != MEM_TIMEOUT).
  - timeout = MEM_WAIT & ~MemReadyM & (wait_cnt == MEM_TIMEOUT).
  - lw_stall = ResultSrcE0 & (RD_E != 0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D)).
- Outputs (combinational, same cycle, priority order):
  1. mem_stall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Memory freeze overrides load-use and branch. A held PCSrcE re-applies on release.
  2. Else:
     - StallF=StallD=lw_stall.
     - FlushD=PCSrcE.
     - FlushE=lw_stall|PCSrcE.
     - StallE=StallM=FlushW=0.
     - If lw_stall and PCSrcE coincide: both flushes assert and StallF/StallD stay 1. The branch redirect wins through the PC mux.
- Transitions (rising clk):
  - RUN -> MEM_WAIT when mem_stall; wait_cnt<=1.
  - MEM_WAIT -> RUN when MemReadyM; wait_cnt<=0.
  - MEM_WAIT -> RUN when timeout; MemErr<=1, wait_cnt<=0. The pipeline releases in the timeout cycle.
  - MEM_WAIT stays when mem_stall; wait_cnt<=wait_cnt+1.
  - Stall length in a single wait is therefore at most MEM_TIMEOUT cycles.
- MemErr: sticky; cleared only by reset.
- Counters:
  - StallCnt += 1 each cycle StallF=1.
  - FlushCnt += 1 each cycle (FlushD|FlushE)=1.
  - Both saturate at all-ones; no wrap.
- wait_cnt width: $clog2(MEM_TIMEOUT+1).
- Reset mid-wait: immediate return to RUN, stalls drop asynchronously.

Decomposition:
- Shared package core_ctrl_pkg:
  - State enum (RUN=1'b0, MEM_WAIT=1'b1).
  - REG_X0 constant (5'd0).
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice for StallCnt and FlushCnt.

Test Plan:
- Reset: hold rst=0 with MemReqM=1, MemReadyM=0 -> all Stall*/Flush*=0, counters 0, MemErr=0. Release rst -> StallF..StallM=1, FlushW=1 in the same cycle.
- Load-use: ResultSrcE0=1, RD_E=5, Rs1_D=5 -> StallF=StallD=1, FlushE=1, FlushD=0 for one cycle; StallCnt=1, FlushCnt=1. Then RD_E=0, Rs1_D=0 -> no stall.
- Branch: PCSrcE=1, no load -> FlushD=FlushE=1, StallF=0. PCSrcE=1 with lw_stall=1 -> FlushD=FlushE=StallF=StallD=1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then MemReadyM=1 -> 3 cycles of full stall + FlushW. Release cycle has StallF=0; state back to RUN; MemErr=0; StallCnt=3.
- Timeout (MEM_TIMEOUT=4): MemReqM=1, MemReadyM=0 held -> stall cycles 1-4, released in cycle 5, MemErr=1 from next edge. MemErr stays 1 after later successful accesses until rst=0.
- Saturation (CNT_W=4): 20 consecutive lw_stall cycles -> StallCnt=15, FlushCnt=15, no wrap.
